star_exp_lut_arbiter: RTL and testbench

- Round-robin arbiter that shares one exponent LUT among N_REQ softmax row engines.
- Each engine presents one-hot subtraction match vectors (xi - xmax mapped onto the CAM line). The arbiter issues one LUT lookup per cycle and returns the tagged exp value to the owning engine.
- It keeps a per-engine running Sum_exp and emits the row sum when the row's last lookup returns.
- Position in the design: between the CAM stage (sub_MV producers) and the shared LUT macro.

---
 rtl/star_exp_lut_arbiter.sv | 153 +++++++++++++++
 tb/tb_star_exp_lut_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/star_exp_lut_arbiter.sv
// Shared exp-LUT arbiter for softmax row engines: round-robin grant, one lookup
// per cycle, tag pipeline aligned to LUT latency, per-engine saturating row sums.

module star_exp_acc_lane #(
    parameter int EXP_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic             last,
    input  logic [EXP_W-1:0] val,
    output logic [EXP_W-1:0] sum,
    output logic             nz
);
    logic [EXP_W-1:0] acc;
    logic [EXP_W:0]   raw;

    assign raw = {1'b0, acc} + {1'b0, val};
    assign sum = raw[EXP_W] ? '1 : raw[EXP_W-1:0];
    assign nz  = |acc;

    // The last beat of a row hands its sum out and restarts the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (hit)
            acc <= last ? '0 : sum;
    end
endmodule

module star_exp_lut_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CAM_LEN = 16,
    parameter int EXP_W   = 32,
    parameter int LUT_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CAM_LEN-1:0]   req_mv,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       lut_en,
    output logic [$clog2(CAM_LEN)-1:0] lut_idx,
    input  logic [EXP_W-1:0]           lut_exp,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [EXP_W-1:0]           rsp_exp,
    output logic                       sum_valid,
    output logic [$clog2(N_REQ)-1:0]   sum_id,
    output logic [EXP_W-1:0]           sum_exp,
    output logic                       mv_err,
    output logic                       busy
);
    localparam int IDW = $clog2(N_REQ);
    localparam int IXW = $clog2(CAM_LEN);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
        logic           zero;
    } tag_t;

    logic [IDW-1:0]     ptr, gid, cand;
    logic               xfer;
    logic [CAM_LEN-1:0] mv;
    logic               mv_none, mv_multi;
    logic [IXW-1:0]     mv_idx;

    logic [LUT_LAT:0]   vld_pipe;
    tag_t               tag_pipe [LUT_LAT:0];
    tag_t               tag_o;
    logic [IXW-1:0]     idx_q;
    logic               err_q;

    logic [N_REQ-1:0][EXP_W-1:0] lane_sum;
    logic [N_REQ-1:0]            lane_nz;

    // N_REQ is a power of two, so the IDW-bit add wraps the search for free.
    always_comb begin
        req_ready = '0;
        gid       = '0;
        xfer      = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDW'(k);
            if (en && !rst && !xfer && req_valid[cand]) begin
                req_ready[cand] = 1'b1;
                gid             = cand;
                xfer            = 1'b1;
            end
        end
    end

    assign mv       = req_mv[gid*CAM_LEN +: CAM_LEN];
    assign mv_none  = (mv == '0);
    assign mv_multi = |(mv & (mv - 1'b1));

    always_comb begin
        mv_idx = '0;
        for (int i = 0; i < CAM_LEN; i++)
            if (mv[i])
                mv_idx = mv_idx | IXW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            vld_pipe <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            for (int s = 0; s <= LUT_LAT; s++)
                tag_pipe[s] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[LUT_LAT-1:0], xfer};
            tag_pipe[0] <= '{id: gid, last: req_last[gid], zero: mv_none | mv_multi};
            for (int s = 1; s <= LUT_LAT; s++)
                tag_pipe[s] <= tag_pipe[s-1];
            idx_q <= mv_idx;
            err_q <= xfer & mv_multi;
            if (xfer)
                ptr <= gid + 1'b1;
        end
    end

    assign lut_en  = vld_pipe[0] & ~tag_pipe[0].zero;
    assign lut_idx = lut_en ? idx_q : '0;
    assign mv_err  = vld_pipe[0] & err_q;

    // Zero-tagged beats never strobed the LUT, so lut_exp is stale for them.
    assign tag_o     = tag_pipe[LUT_LAT];
    assign rsp_valid = vld_pipe[LUT_LAT];
    assign rsp_id    = rsp_valid ? tag_o.id : '0;
    assign rsp_exp   = (rsp_valid && !tag_o.zero) ? lut_exp : '0;
    assign sum_valid = rsp_valid & tag_o.last;
    assign sum_id    = sum_valid ? tag_o.id : '0;
    assign sum_exp   = sum_valid ? lane_sum[tag_o.id] : '0;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        star_exp_acc_lane #(.EXP_W(EXP_W)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .hit  (rsp_valid && (tag_o.id == IDW'(g))),
            .last (tag_o.last),
            .val  (rsp_exp),
            .sum  (lane_sum[g]),
            .nz   (lane_nz[g])
        );
    end

    assign busy = (|vld_pipe) | (|lane_nz);
endmodule

// File: tb/tb_star_exp_lut_arbiter.sv
// Directed bench for star_exp_lut_arbiter: engine beat queues, a 1-cycle LUT
// model, and a negedge monitor whose records are compared to hand-computed values.

module tb_star_exp_lut_arbiter;
    localparam int N_REQ   = 4;
    localparam int CAM_LEN = 16;
    localparam int EXP_W   = 32;

    logic                     clk = 1'b0;
    logic                     rst, en;
    logic [N_REQ-1:0]         req_valid, req_last, req_ready;
    logic [N_REQ*CAM_LEN-1:0] req_mv;
    logic                     lut_en;
    logic [3:0]               lut_idx;
    logic [EXP_W-1:0]         lut_exp = '0;
    logic                     rsp_valid, sum_valid, mv_err, busy;
    logic [1:0]               rsp_id, sum_id;
    logic [EXP_W-1:0]         rsp_exp, sum_exp;

    star_exp_lut_arbiter #(.N_REQ(N_REQ), .CAM_LEN(CAM_LEN), .EXP_W(EXP_W), .LUT_LAT(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_mv(req_mv),
        .req_last(req_last), .req_ready(req_ready), .lut_en(lut_en), .lut_idx(lut_idx),
        .lut_exp(lut_exp), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_exp(rsp_exp),
        .sum_valid(sum_valid), .sum_id(sum_id), .sum_exp(sum_exp), .mv_err(mv_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] tbl [16];
    always @(posedge clk) lut_exp <= lut_en ? tbl[lut_idx] : 32'hDEAD_BEEF;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          g_id[$], g_cyc[$], e_cyc[$], r_id[$], r_cyc[$], s_id[$], li_q[$];
    logic [31:0] r_exp[$], s_exp[$];
    logic [16:0] bq [N_REQ][$];

    always @(negedge clk) begin
        for (int i = 0; i < N_REQ; i++)
            if (req_ready[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        if (lut_en) li_q.push_back(int'(lut_idx));
        if (mv_err) e_cyc.push_back(cyc);
        if (rsp_valid) begin
            r_id.push_back(int'(rsp_id));
            r_exp.push_back(rsp_exp);
            r_cyc.push_back(cyc);
        end
        if (sum_valid) begin
            s_id.push_back(int'(sum_id));
            s_exp.push_back(sum_exp);
        end
    end

    task automatic clr();
        g_id.delete(); g_cyc.delete(); e_cyc.delete(); li_q.delete();
        r_id.delete(); r_exp.delete(); r_cyc.delete(); s_id.delete(); s_exp.delete();
    endtask

    // Presents each engine's queue head until granted; ends 4 idle cycles after the last beat.
    task automatic run(input int budget);
        int n, tail;
        logic [N_REQ-1:0] g;
        n = 0;
        tail = 0;
        while (tail < 4 && n < budget) begin
            req_valid = '0; req_mv = '0; req_last = '0;
            for (int i = 0; i < N_REQ; i++)
                if (bq[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_mv[i*CAM_LEN +: CAM_LEN] = bq[i][0][15:0];
                    req_last[i] = bq[i][0][16];
                end
            @(negedge clk);
            g = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N_REQ; i++)
                if (g[i]) void'(bq[i].pop_front());
            tail = (req_valid == '0) ? tail + 1 : 0;
            n++;
        end
        req_valid = '0; req_mv = '0; req_last = '0;
        chk("run_budget_expired", 64'(n >= budget), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        tbl[0] = 10; tbl[1] = 20; tbl[2] = 30; tbl[15] = 40;
        tbl[3] = 32'hFFFF_FFF0; tbl[4] = 32'h20;
        tbl[5] = 50; tbl[6] = 5; tbl[7] = 7;
        for (int k = 8; k <= 14; k++) tbl[k] = 32'((k - 7) * 1000);

        // reset state, with every engine requesting
        rst = 1'b1; en = 1'b1; req_valid = '1; req_mv = {N_REQ{16'h0001}}; req_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_lut_en", lut_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_mv_err", mv_err, 0);
        chk("rst_busy", busy, 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        clr();

        // single engine 0 row of 4
        bq[0].push_back({1'b0, 16'h0001}); bq[0].push_back({1'b0, 16'h0002});
        bq[0].push_back({1'b0, 16'h0004}); bq[0].push_back({1'b1, 16'h8000});
        run(60);
        chk("t1_grants", g_id.size(), 4);
        chk("t1_rsp_cnt", r_exp.size(), 4);
        chk("t1_lut_cnt", li_q.size(), 4);
        for (int k = 0; k < 4 && k < r_exp.size() && k < g_cyc.size() && k < li_q.size(); k++) begin
            chk($sformatf("t1_rsp_exp%0d", k), r_exp[k], 64'((k + 1) * 10));
            chk($sformatf("t1_rsp_id%0d", k), r_id[k], 0);
            chk($sformatf("t1_latency%0d", k), r_cyc[k], g_cyc[k] + 2);
            chk($sformatf("t1_lut_idx%0d", k), li_q[k], (k == 3) ? 15 : k);
        end
        chk("t1_sum_cnt", s_exp.size(), 1);
        if (s_exp.size() > 0) begin
            chk("t1_sum_exp", s_exp[0], 100);
            chk("t1_sum_id", s_id[0], 0);
        end
        chk("t1_busy_idle", busy, 0);
        clr();

        // saturation on engine 3 (also leaves the pointer at 0)
        bq[3].push_back({1'b0, 16'h0008}); bq[3].push_back({1'b1, 16'h0010});
        run(60);
        chk("t4_rsp_cnt", r_exp.size(), 2);
        if (r_exp.size() > 0) chk("t4_rsp_exp0", r_exp[0], 32'hFFFF_FFF0);
        chk("t4_sum_cnt", s_exp.size(), 1);
        if (s_exp.size() > 0) begin
            chk("t4_sum_exp", s_exp[0], 32'hFFFF_FFFF);
            chk("t4_sum_id", s_id[0], 3);
        end
        chk("t4_busy_idle", busy, 0);
        clr();

        // all engines, 3 beats each: engine i beat j reads entry 8+i+j
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 3; j++) begin
                m = 16'h1 << (8 + i + j);
                bq[i].push_back({(j == 2) ? 1'b1 : 1'b0, m});
            end
        run(80);
        chk("t2_grants", g_id.size(), 12);
        chk("t2_rsp_cnt", r_exp.size(), 12);
        for (int k = 0; k < 12 && k < g_id.size() && k < r_exp.size(); k++) begin
            chk($sformatf("t2_grant%0d", k), g_id[k], k % 4);
            chk($sformatf("t2_gcyc%0d", k), g_cyc[k], g_cyc[0] + k);
            chk($sformatf("t2_rsp_id%0d", k), r_id[k], k % 4);
            chk($sformatf("t2_rsp_exp%0d", k), r_exp[k], 64'((1 + k % 4 + k / 4) * 1000));
        end
        chk("t2_sum_cnt", s_exp.size(), 4);
        for (int i = 0; i < 4 && i < s_exp.size(); i++) begin
            chk($sformatf("t2_sum_id%0d", i), s_id[i], i);
            chk($sformatf("t2_sum_exp%0d", i), s_exp[i], 64'((6 + 3 * i) * 1000));
        end
        clr();

        // engine 2: out-of-range mv, then multi-hot mv
        bq[2].push_back({1'b0, 16'h0000}); bq[2].push_back({1'b1, 16'h0003});
        run(60);
        chk("t3_lut_cnt", li_q.size(), 0);
        chk("t3_err_cnt", e_cyc.size(), 1);
        if (e_cyc.size() > 0 && g_cyc.size() > 1) chk("t3_err_cyc", e_cyc[0], g_cyc[1] + 1);
        chk("t3_rsp_cnt", r_exp.size(), 2);
        for (int k = 0; k < r_exp.size() && k < 2; k++) chk($sformatf("t3_rsp_exp%0d", k), r_exp[k], 0);
        chk("t3_sum_cnt", s_exp.size(), 1);
        if (s_exp.size() > 0) begin
            chk("t3_sum_exp", s_exp[0], 0);
            chk("t3_sum_id", s_id[0], 2);
        end
        clr();

        // en dropped with two engine-0 beats in flight
        req_valid = 4'b0001; req_mv = '0; req_mv[15:0] = 16'h0100; req_last = '0;
        @(negedge clk); chk("t5_grant_a", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_mv[15:0] = 16'h0200; req_last = 4'b0001;
        @(negedge clk); chk("t5_grant_b", req_ready, 4'b0001);
        @(posedge clk); #1;
        en = 1'b0; req_valid = 4'b0011; req_mv[15:0] = 16'h0400; req_mv[31:16] = 16'h0800;
        @(negedge clk); chk("t5_ready_dropped", req_ready, 0);
        repeat (4) begin @(posedge clk); #1; end
        req_valid = '0; req_last = '0; req_mv = '0; en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("t5_grants", g_id.size(), 2);
        chk("t5_rsp_cnt", r_exp.size(), 2);
        if (r_exp.size() > 1) begin
            chk("t5_rsp_exp0", r_exp[0], 1000);
            chk("t5_rsp_exp1", r_exp[1], 2000);
        end
        chk("t5_sum_cnt", s_exp.size(), 1);
        if (s_exp.size() > 0) chk("t5_sum_exp", s_exp[0], 3000);
        chk("t5_busy_idle", busy, 0);
        clr();

        // reset with acc[1] = 50 and one lookup in flight
        bq[1].push_back({1'b0, 16'h0020});
        run(60);
        if (r_exp.size() > 0) chk("t6_rsp_exp50", r_exp[0], 50);
        chk("t6_busy_acc", busy, 1);
        req_valid = 4'b0010; req_mv = '0; req_mv[31:16] = 16'h0040; req_last = '0;
        @(negedge clk); chk("t6_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; req_mv = '0;
        clr();
        #1 chk("t6_busy_rst", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("t6_no_rsp", r_exp.size(), 0);
        chk("t6_no_sum", s_exp.size(), 0);
        clr();
        bq[1].push_back({1'b0, 16'h0040}); bq[1].push_back({1'b1, 16'h0080});
        run(60);
        chk("t6_sum_cnt", s_exp.size(), 1);
        if (s_exp.size() > 0) begin
            chk("t6_sum_exp", s_exp[0], 12);
            chk("t6_sum_id", s_id[0], 1);
        end
        chk("t6_busy_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
